// File: rtl/c7bmem_arb.sv
// Single-port memory arbiter merging instruction fetch and LSU load/store onto one bus.
// Optional round-robin between fetch and LSU: define C7B_MEM_ARB_RR_EN.
module c7bmem_arb #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_icu_req_ic1,
  input  logic [AW-1:0]   ifu_icu_addr_ic1,
  output logic            icu_ifu_ack_ic1,
  input  logic            ifu_icu_cancel,
  output logic [DW-1:0]   icu_ifu_data_ic2,
  output logic            icu_ifu_data_valid_ic2,
  input  logic            lsu_biu_rd_req,
  input  logic [AW-1:0]   lsu_biu_rd_addr,
  output logic            biu_lsu_rd_ack,
  output logic            biu_lsu_data_valid,
  output logic [DW-1:0]   biu_lsu_data,
  input  logic            lsu_biu_wr_req,
  input  logic [AW-1:0]   lsu_biu_wr_addr,
  input  logic [DW-1:0]   lsu_biu_wr_data,
  input  logic [DW/8-1:0] lsu_biu_wr_strb,
  output logic            biu_lsu_wr_ack,
  output logic            biu_lsu_write_done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    LD_WAIT = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic sel_if;
  logic sel_ld;
  logic sel_st;
  logic any_req;
  logic grant;
  logic cancel_pend;
  logic cancel_now;
  logic rsp_if;
  logic rsp_ld;
  logic rsp_st;

  assign any_req = ifu_icu_req_ic1 | lsu_biu_rd_req | lsu_biu_wr_req;

`ifdef C7B_MEM_ARB_RR_EN
  // last_if set: LSU favoured next; clear: fetch favoured next
  logic last_if;

  always_comb begin
    sel_if = 1'b0;
    sel_ld = 1'b0;
    sel_st = 1'b0;
    if (last_if) begin
      sel_st = lsu_biu_wr_req;
      sel_ld = lsu_biu_rd_req & ~lsu_biu_wr_req;
      sel_if = ifu_icu_req_ic1 & ~lsu_biu_wr_req & ~lsu_biu_rd_req;
    end else begin
      sel_if = ifu_icu_req_ic1;
      sel_st = lsu_biu_wr_req & ~ifu_icu_req_ic1;
      sel_ld = lsu_biu_rd_req & ~lsu_biu_wr_req & ~ifu_icu_req_ic1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_if <= 1'b1;
    end else if (grant) begin
      last_if <= sel_if;
    end
  end
`else
  // LSU beats fetch so an EXU stall on a load/store resolves first
  assign sel_st = lsu_biu_wr_req;
  assign sel_ld = lsu_biu_rd_req & ~lsu_biu_wr_req;
  assign sel_if = ifu_icu_req_ic1 & ~lsu_biu_wr_req & ~lsu_biu_rd_req;
`endif

  assign grant = mem_req & mem_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          if (sel_st) begin
            state_nxt = ST_WAIT;
          end else if (sel_ld) begin
            state_nxt = LD_WAIT;
          end else begin
            state_nxt = IF_WAIT;
          end
        end
      end
      IF_WAIT, LD_WAIT, ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request mux and same-cycle acks, held off during reset
  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_wstrb       = '0;
    icu_ifu_ack_ic1 = 1'b0;
    biu_lsu_rd_ack  = 1'b0;
    biu_lsu_wr_ack  = 1'b0;
    if ((state == IDLE) && !reset) begin
      mem_req = any_req;
      if (sel_st) begin
        mem_we    = 1'b1;
        mem_addr  = lsu_biu_wr_addr;
        mem_wdata = lsu_biu_wr_data;
        mem_wstrb = lsu_biu_wr_strb;
      end else if (sel_ld) begin
        mem_addr = lsu_biu_rd_addr;
      end else if (sel_if) begin
        mem_addr = ifu_icu_addr_ic1;
      end
      icu_ifu_ack_ic1 = sel_if & mem_gnt;
      biu_lsu_rd_ack  = sel_ld & mem_gnt;
      biu_lsu_wr_ack  = sel_st & mem_gnt;
    end
  end

  assign rsp_if     = (state == IF_WAIT) & mem_rsp_valid;
  assign rsp_ld     = (state == LD_WAIT) & mem_rsp_valid;
  assign rsp_st     = (state == ST_WAIT) & mem_rsp_valid;
  assign cancel_now = cancel_pend | ifu_icu_cancel;

  // Registered responses; a cancelled fetch completes on the bus but is swallowed
  always_ff @(posedge clk) begin
    if (reset) begin
      icu_ifu_data_valid_ic2 <= 1'b0;
      icu_ifu_data_ic2       <= '0;
      biu_lsu_data_valid     <= 1'b0;
      biu_lsu_data           <= '0;
      biu_lsu_write_done     <= 1'b0;
      cancel_pend            <= 1'b0;
    end else begin
      icu_ifu_data_valid_ic2 <= rsp_if & ~cancel_now;
      biu_lsu_data_valid     <= rsp_ld;
      biu_lsu_write_done     <= rsp_st;
      if (rsp_if && !cancel_now) begin
        icu_ifu_data_ic2 <= mem_rdata;
      end
      if (rsp_ld) begin
        biu_lsu_data <= mem_rdata;
      end
      if (rsp_if) begin
        cancel_pend <= 1'b0;
      end else if (ifu_icu_cancel && ((state == IF_WAIT) || icu_ifu_ack_ic1)) begin
        cancel_pend <= 1'b1;
      end
    end
  end

endmodule

// File: doc/c7bmem_arb.md
# c7bmem_arb

Single-port memory arbiter below `c7bcore`. It merges the core's instruction-fetch port (`ifu_icu_*`/`icu_ifu_*`) and LSU read/write ports (`lsu_biu_*`/`biu_lsu_*`) onto one 64-bit memory bus. The bus allows one outstanding transaction. The arbiter issues core requests, returns registered responses to the originating port, and honours instruction-fetch cancel.

## Interface
- `AW`, default 32: address width, on the core ports and the memory port.
- `DW`, default 64: data width. `DW/8` is the strobe width.

Ports (name, direction, width, meaning):
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high reset
- `ifu_icu_req_ic1`  in  1  fetch request; held until acked
- `ifu_icu_addr_ic1`  in  AW  fetch address; stable while req is high
- `icu_ifu_ack_ic1`  out  1  fetch accepted
- `ifu_icu_cancel`  in  1  discard the pending fetch response
- `icu_ifu_data_ic2`  out  DW  fetch data
- `icu_ifu_data_valid_ic2`  out  1  fetch data valid, 1-cycle pulse
- `lsu_biu_rd_req`  in  1  load request; held until acked
- `lsu_biu_rd_addr`  in  AW  load address
- `biu_lsu_rd_ack`  out  1  load accepted
- `biu_lsu_data_valid`  out  1  load data valid, 1-cycle pulse
- `biu_lsu_data`  out  DW  load data
- `lsu_biu_wr_req`  in  1  store request; held until acked
- `lsu_biu_wr_addr`  in  AW  store address
- `lsu_biu_wr_data`  in  DW  store data
- `lsu_biu_wr_strb`  in  DW/8  byte enables
- `biu_lsu_wr_ack`  out  1  store accepted
- `biu_lsu_write_done`  out  1  store completed, 1-cycle pulse
- `mem_req`  out  1  bus request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  AW  bus address
- `mem_wdata`  out  DW  bus write data
- `mem_wstrb`  out  DW/8  bus byte enables
- `mem_gnt`  in  1  bus accepts the request this cycle
- `mem_rsp_valid`  in  1  read data or write completion
- `mem_rdata`  in  DW  bus read data

## Operation
- States:
  - `IDLE`
  - `IF_WAIT`
  - `LD_WAIT`
  - `ST_WAIT`
- Only one transaction is in flight at a time. `mem_req` is asserted only in `IDLE`.
- In `IDLE`, a requester is selected combinationally from the asserted requests. Fixed priority is store > load > fetch. LSU wins over fetch so that the EXU stall resolves.
- `mem_req` = `IDLE` & any request. `mem_we`/`mem_addr`/`mem_wdata`/`mem_wstrb` are muxed from the selected requester.
  - `mem_wdata` and `mem_wstrb` are zero for reads.
- Grant: in the cycle where `mem_req & mem_gnt` holds:
  - the selected port's ack pulses combinationally;
  - the state moves to the matching `*_WAIT` state at the next edge.
- Without `mem_gnt`, no ack is given. The requester keeps its request and the arbiter re-arbitrates every cycle, so a higher-priority request arriving meanwhile wins.
- `*_WAIT` + `mem_rsp_valid`:
  - `mem_rdata` is captured into the port's data register;
  - the port's valid/done pulse asserts for the following cycle;
  - the state returns to `IDLE`.
- Cancel:
  - `ifu_icu_cancel` during `IF_WAIT`, or in the fetch-ack cycle, sets `cancel_pend`.
  - The bus transaction still completes, but `icu_ifu_data_valid_ic2` is suppressed. `cancel_pend` clears when the response is absorbed.
  - Cancel in `IDLE` with no fetch ack is ignored.
- Store-done carries no data. `biu_lsu_data` is only updated by loads.
- `mem_rsp_valid` in `IDLE` is ignored. This covers stale responses after reset.

## Timing
- Reset (synchronous): state `IDLE`; `cancel_pend`=0; all valid/done pulses 0; `icu_ifu_data_ic2`=0; `biu_lsu_data`=0.
  - Acks and `mem_req` are 0 during the reset cycle: they are gated by `~reset`.
- Request-to-ack: 0 cycles after `mem_gnt`, the same cycle.
- Response latency: valid/done is high exactly 1 cycle after `mem_rsp_valid`. Data is stable from that cycle until the next response to the same port.
- Back-to-back: a new request can issue in the same cycle its predecessor's valid/done is high. With a zero-wait memory (`mem_gnt`=1, rsp in the next cycle), throughput is 1 transaction per 2 cycles.
- The earliest legal `mem_rsp_valid` is 1 cycle after grant. A rsp in the grant cycle is a bus protocol violation and is ignored.
- Reset mid-transaction: the outstanding transaction is dropped and no valid/done is emitted. The memory side is reset concurrently.

## Configuration
- `C7B_MEM_ARB_RR_EN`: defined selects round-robin between the fetch and LSU ports.
  - A `last_if` flop records whether the previous grant was a fetch. After a fetch grant, the LSU has priority; after an LSU grant, fetch has priority.
  - Store > load still holds within the LSU.
  - Reset value of `last_if` is 1, so the LSU is favoured first.
- Undefined: fixed priority store > load > fetch, with no extra state.

## Test plan
- Fetch only, `mem_gnt`=1: fetch to `0x1c000000` with `mem_rdata`=`0x0000_0013_0280_0004` → ack in cycle 0; `mem_rsp_valid` in cycle 1; `icu_ifu_data_valid_ic2`=1 in cycle 2 with that data.
- Simultaneous fetch `0x1c000008` + load `0x00001000` (fixed priority) → load granted first, `mem_we`=0, addr `0x1000`; fetch acked in the cycle load data_valid is high.
- Store `0x2000`, data `0xDEADBEEF_CAFEF00D`, strb `0x0F`, `mem_gnt` held low 3 cycles → no ack for 3 cycles; ack in cycle 3 with `mem_we`=1, `mem_wstrb`=`0x0F`; `biu_lsu_write_done` 1 cycle after rsp; `biu_lsu_data` unchanged.
- Fetch acked, `ifu_icu_cancel` pulsed in `IF_WAIT`, rsp after 4 cycles → no `icu_ifu_data_valid_ic2`; next fetch returns data normally.
- `reset` asserted in `LD_WAIT`, then rsp arrives after reset is released → no `biu_lsu_data_valid`; all outputs 0.
- With `C7B_MEM_ARB_RR_EN`: fetch and load both held continuously → grants alternate load, fetch, load, fetch.
